// File: rtl/riscvx_hazard_pkg.sv
// Shared types and constants for the RISCVX pipeline hazard controller.
package riscvx_hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_wait_timer.sv
// Counts data-memory wait cycles; expired flags the last permitted stall cycle.
module hazard_wait_timer
    import riscvx_hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic ack,
    input  logic clear,
    output logic expired
);

    logic [CNT_W-1:0] wcnt;

    // A nonzero count means a wait is in progress; zero is the idle value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wcnt <= '0;
        else if (clear || ack)
            wcnt <= '0;
        else if (start)
            wcnt <= CNT_W'(1);
        else if (wcnt != '0)
            wcnt <= wcnt + CNT_W'(1);
    end

    assign expired = (wcnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect, memory wait and timeout fault.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl
    import riscvx_hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        use_rs1_ID,
    input  logic        use_rs2_ID,
    input  logic [4:0]  rd_EX,
    input  logic        memread_EX,
    input  logic        redirect_EX,
    input  logic        mem_req_MEM,
    input  logic        mem_ack_MEM,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        stall_idex,
    output logic        stall_exmem,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        wbff,
    output logic        mem_fault,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    hz_state_t state;
    logic memwait, loaduse, hold, expired;

    assign memwait = mem_req_MEM & ~mem_ack_MEM;
    assign loaduse = memread_EX & (rd_EX != REG_X0) &
                     ((use_rs1_ID & (rs1_ID == rd_EX)) | (use_rs2_ID & (rs2_ID == rd_EX)));
    // Once waiting, stalls persist until the ack even if the request drops.
    assign hold    = (state == WAIT) ? ~mem_ack_MEM : memwait;

    hazard_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   ((state == RUN) & memwait),
        .ack     ((state == WAIT) & mem_ack_MEM),
        .clear   ((state != RUN) & (state != WAIT)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (memwait) state <= WAIT;
                WAIT:    if (mem_ack_MEM) state <= RUN;
                         else if (expired) state <= FAULT;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        wbff        = 1'b0;
        mem_fault   = 1'b0;
        if (reset_n) begin
            if (state == FAULT) begin
                wbff       = 1'b1;
                mem_fault  = 1'b1;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (state == RUN || state == WAIT) begin
                if (hold) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    stall_idex  = 1'b1;
                    stall_exmem = 1'b1;
                end else if (redirect_EX) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (loaduse) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_pc)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_idex) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
